multiport_register_file: RTL and testbench
==========================================

Name: multiport_register_file

Overview:
- Parametrised general-purpose register file for the 5-stage pipelined RISC-V core; sits between ID (reads) and WB (writes).
- Generalises the single-write/dual-read file:
  - configurable width, depth and port counts;
  - register 0 hardwired to zero;
  - optional write-to-read bypass for the WB->ID hazard;
  - sequential clear engine that zeroes the array after reset or on request, with ready handshake.

Parameters:
- DATA_WIDTH, 64, bits per register
- NUM_REGS, 32, number of architectural registers; power of two, >=4
- ADDR_WIDTH, $clog2(NUM_REGS), register index width
- NUM_READ, 2, read ports, 1..4
- NUM_WRITE, 2, write ports, 1..2
- ZERO_REG0, 1, 1: index 0 always reads 0 and writes to it are dropped
- BYPASS, 1, 1: same-cycle write data forwarded to matching read ports

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high
- clear_req  input  1  single-cycle pulse; starts a clear sweep
- ready  output  1  1 = idle, reads/writes valid; 0 = clear sweep in progress
- rs  input  NUM_READ*ADDR_WIDTH  read indices, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- ReadData  output  NUM_READ*DATA_WIDTH  read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
- RegWrite  input  NUM_WRITE  per-port write enable
- rd  input  NUM_WRITE*ADDR_WIDTH  write indices
- WriteData  input  NUM_WRITE*DATA_WIDTH  write data

Behaviour:
- States: CLEAR, IDLE.
- Reset asserted (any time, including mid-sweep):
  - state=CLEAR, clear counter=0, ready=0 immediately;
  - array contents are not reset asynchronously.
- CLEAR:
  - each rising edge writes 0 to Registers[counter], counter increments;
  - when counter==NUM_REGS-1 is written, next state IDLE, ready=1;
  - sweep takes NUM_REGS cycles after reset deasserts.
  - All RegWrite inputs ignored; ReadData forced to 0; clear_req ignored (no restart).
- IDLE:
  - clear_req=1 -> CLEAR, counter=0, ready=0 next cycle.
  - clear_req has priority over RegWrite in the same cycle: the write is dropped.
- Writes (IDLE only): on rising edge, for each port w with RegWrite[w]=1, Registers[rd[w]] <= WriteData[w].
  - If both ports target the same index, port 1 wins.
  - With ZERO_REG0=1, rd==0 writes are dropped.
- Reads: combinational, zero latency; ReadData[i] = Registers[rs[i]].
  - ZERO_REG0=1 and rs[i]==0 -> 0, overriding the bypass.
  - BYPASS=1 and a port has RegWrite=1 with rd==rs[i] in the same cycle (IDLE) -> that port's WriteData is returned, highest-numbered matching port wins.
  - BYPASS=0 -> stored value; the new value is visible the cycle after the write.
- Width rules: indices >= NUM_REGS cannot occur (power-of-two depth); no sign/zero extension is performed.
- ready is a registered output, 0 from reset assertion until the sweep completes.

Decomposition:
- Shared package rf_pkg:
  - default DATA_WIDTH/NUM_REGS constants;
  - state enum (RF_CLEAR, RF_IDLE);
  - function for priority merge of write ports.
- One sub-module rf_clear_ctrl:
  - FSM + counter;
  - outputs clear_we, clear_addr, ready.
- Storage array, write merge and read/bypass muxes stay in the top module.

Test Plan:
- Reset pulse, then hold: ready=0 for 32 cycles after reset deasserts, then 1; every rs reads 0 once ready=1 (all 32 indices).
- IDLE, port0 writes rd=5 data=0x1234: bypass read rs0=5 returns 0x1234 in the same cycle; next cycle returns 0x1234 from storage. With BYPASS=0, the same-cycle read returns the old value 0.
- Both ports write rd=7 (port0=0xAAAA, port1=0xBBBB): the next-cycle read of 7 returns 0xBBBB. Write rd=0 with 0xFFFF: rs=0 reads 0 in the same and next cycles.
- Fill regs 1..31 with i*3, then pulse clear_req together with a write to rd=9:
  - ready falls next cycle;
  - the write is dropped;
  - after 32 cycles all reads return 0.
- Assert reset asynchronously at sweep counter=10 (mid-edge): ready=0 without waiting for a clock edge, ReadData=0; after deassert, a full 32-cycle sweep restarts from index 0.
- NUM_READ=4, NUM_WRITE=1, DATA_WIDTH=32, NUM_REGS=16: write rd=15 value 0xDEADBEEF; all four ports with rs=15 read 0xDEADBEEF; the sweep takes 16 cycles.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the multiport register file.
//   - Default geometry constants for the pipeline's integer register file.
//   - Clear-engine state encoding.
//   - rf_merge(): resolves which write port (if any) targets a given index,
//     with the highest-numbered port winning. It is used both for storage
//     updates and for the write-to-read bypass so the two always agree.
// No ports; imported by the interface users and the register file modules.
package rf_pkg;

  localparam int RF_DEFAULT_DATA_WIDTH = 64;
  localparam int RF_DEFAULT_NUM_REGS   = 32;

  // The merge helper is sized for the largest supported configuration:
  // up to two write ports and register indices up to 8 bits (256 regs).
  localparam int RF_MAX_WRITE = 2;
  localparam int RF_IDX_W     = 8;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_IDLE  = 1'b1
  } rf_state_e;

  typedef logic [RF_IDX_W-1:0] rf_idx_t;
  typedef rf_idx_t [RF_MAX_WRITE-1:0] rf_idx_vec_t;

  typedef struct packed {
    logic hit;
    logic port;
  } rf_sel_t;

  // Scans ports in ascending order so a later (higher-numbered) match
  // overrides an earlier one.
  function automatic rf_sel_t rf_merge(input logic [RF_MAX_WRITE-1:0] en,
                                       input rf_idx_vec_t             idx,
                                       input rf_idx_t                 target);
    rf_sel_t sel;
    sel = '0;
    for (int w = 0; w < RF_MAX_WRITE; w++) begin
      if (en[w] && (idx[w] == target)) begin
        sel.hit  = 1'b1;
        sel.port = w[0];
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/multiport_register_file_if.sv
// Bus between the pipeline (ID reads, WB writes) and the register file.
//   clear_req  : pulse requesting a full clear sweep
//   ready      : 1 when the file is idle and usable
//   rs         : packed read indices, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   ReadData   : packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   RegWrite   : per-port write enables
//   rd         : packed write indices
//   WriteData  : packed write data
// master = pipeline side, slave = register file side.
interface multiport_register_file_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2
);

  logic                            clear_req;
  logic                            ready;
  logic [NUM_READ*ADDR_WIDTH-1:0]  rs;
  logic [NUM_READ*DATA_WIDTH-1:0]  ReadData;
  logic [NUM_WRITE-1:0]            RegWrite;
  logic [NUM_WRITE*ADDR_WIDTH-1:0] rd;
  logic [NUM_WRITE*DATA_WIDTH-1:0] WriteData;

  modport master (
    output clear_req, rs, RegWrite, rd, WriteData,
    input  ready, ReadData
  );

  modport slave (
    input  clear_req, rs, RegWrite, rd, WriteData,
    output ready, ReadData
  );

endinterface

// File: rtl/rf_clear_ctrl.sv
// Clear engine for the register file: after reset, or when clear_req is
// seen while idle, it walks every index from 0 to NUM_REGS-1, asking the
// array to write zero at one index per cycle, then returns to idle.
//   clk, reset  : clock and asynchronous active-high reset
//   clear_req   : request a new sweep (honoured only when idle)
//   clear_we    : 1 while sweeping; array writes 0 at clear_addr
//   clear_addr  : index being cleared this cycle
//   ready       : registered, 1 only when idle
module rf_clear_ctrl
  import rf_pkg::*;
#(
  parameter int NUM_REGS   = RF_DEFAULT_NUM_REGS,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_req,
  output logic                  clear_we,
  output logic [ADDR_WIDTH-1:0] clear_addr,
  output logic                  ready
);

  rf_state_e             state, stateNext;
  logic [ADDR_WIDTH-1:0] count, countNext;

  // State, sweep counter and ready register. ready is derived from the next
  // state so it rises on the same edge that clears the last index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RF_CLEAR;
      count <= '0;
      ready <= 1'b0;
    end else begin
      state <= stateNext;
      count <= countNext;
      ready <= (stateNext == RF_IDLE);
    end
  end

  // Sweep sequencing. clear_req during a sweep is ignored; a new request
  // from idle restarts the walk at index 0.
  always_comb begin
    stateNext = state;
    countNext = count;
    case (state)
      RF_CLEAR: begin
        countNext = count + ADDR_WIDTH'(1);
        if (count == ADDR_WIDTH'(NUM_REGS - 1)) begin
          stateNext = RF_IDLE;
        end
      end
      RF_IDLE: begin
        if (clear_req) begin
          stateNext = RF_CLEAR;
          countNext = '0;
        end
      end
      default: begin
        stateNext = RF_CLEAR;
        countNext = '0;
      end
    endcase
  end

  assign clear_we   = (state == RF_CLEAR);
  assign clear_addr = count;

endmodule

// File: rtl/multiport_register_file.sv
// Multiport general-purpose register file for the 5-stage RISC-V core.
// Reads are combinational; writes land on the rising edge while idle.
// Register 0 can be hardwired to zero, and same-cycle write data can be
// forwarded to matching read ports to cover the WB->ID hazard.
//   clk    : clock
//   reset  : asynchronous active-high reset; starts a clear sweep
//   bus    : slave side of multiport_register_file_if (clear_req, ready,
//            rs/ReadData read ports, RegWrite/rd/WriteData write ports)
module multiport_register_file
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DEFAULT_DATA_WIDTH,
  parameter int NUM_REGS   = RF_DEFAULT_NUM_REGS,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2,
  parameter bit ZERO_REG0  = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input logic                       clk,
  input logic                       reset,
  multiport_register_file_if.slave  bus
);

  logic                  clearWe;
  logic [ADDR_WIDTH-1:0] clearAddr;
  logic                  readyQ;

  rf_clear_ctrl #(
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear (
    .clk        (clk),
    .reset      (reset),
    .clear_req  (bus.clear_req),
    .clear_we   (clearWe),
    .clear_addr (clearAddr),
    .ready      (readyQ)
  );

  assign bus.ready = readyQ;

  logic [DATA_WIDTH-1:0]                    regs [NUM_REGS];
  logic [RF_MAX_WRITE-1:0]                  byEn;
  logic [RF_MAX_WRITE-1:0]                  wrEn;
  rf_idx_vec_t                              wrIdx;
  logic [RF_MAX_WRITE-1:0][DATA_WIDTH-1:0]  wrData;
  rf_sel_t                                  wrSel [NUM_REGS];

  // Unpack the write ports into fixed-size vectors for rf_merge. byEn is the
  // raw idle-time enable used for forwarding; wrEn additionally drops writes
  // that lose to clear_req or that target a hardwired register 0.
  always_comb begin
    byEn   = '0;
    wrEn   = '0;
    wrIdx  = '0;
    wrData = '0;
    for (int w = 0; w < NUM_WRITE; w++) begin
      wrIdx[w]  = RF_IDX_W'(bus.rd[w*ADDR_WIDTH +: ADDR_WIDTH]);
      wrData[w] = bus.WriteData[w*DATA_WIDTH +: DATA_WIDTH];
      byEn[w]   = bus.RegWrite[w] & readyQ;
      wrEn[w]   = byEn[w] & ~bus.clear_req & ~(ZERO_REG0 && (wrIdx[w] == '0));
    end
  end

  // Per-register winner among the write ports (highest port wins).
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      wrSel[r] = rf_merge(wrEn, wrIdx, RF_IDX_W'(r));
    end
  end

  // Storage has no reset; the clear engine zeroes it after reset instead.
  // Sweep writes and port writes never coincide since ports only write idle.
  always_ff @(posedge clk) begin
    if (clearWe) begin
      regs[clearAddr] <= '0;
    end
    for (int r = 0; r < NUM_REGS; r++) begin
      if (wrSel[r].hit) begin
        regs[r] <= wrData[wrSel[r].port];
      end
    end
  end

  // Read muxes: stored value, optionally replaced by forwarded write data,
  // then forced to zero for register 0 or while a sweep is running.
  always_comb begin
    logic [ADDR_WIDTH-1:0] rsIdx;
    logic [DATA_WIDTH-1:0] data;
    rf_sel_t               rdSel;
    bus.ReadData = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      rsIdx = bus.rs[i*ADDR_WIDTH +: ADDR_WIDTH];
      rdSel = rf_merge(byEn, wrIdx, RF_IDX_W'(rsIdx));
      data  = regs[rsIdx];
      if (BYPASS && rdSel.hit) begin
        data = wrData[rdSel.port];
      end
      if ((ZERO_REG0 && (rsIdx == '0)) || !readyQ) begin
        data = '0;
      end
      bus.ReadData[i*DATA_WIDTH +: DATA_WIDTH] = data;
    end
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Self-checking bench for multiport_register_file. Two instances:
//   dutA: 64-bit, 32 regs, 2 read / 2 write ports, bypass on
//   dutB: 32-bit, 16 regs, 4 read / 1 write port, bypass off
// One driver exercises the active instance; each cycle it predicts the
// response from a behavioural model and queues it. A monitor pops and
// compares on the falling edge.
module tb_multiport_register_file;

  logic clk;
  logic reset;
  bit   phaseB;

  int          cfgRegs;
  int          cfgRead;
  int          cfgWrite;
  bit          cfgBypass;
  logic [63:0] cfgMask;

  logic [4:0]  drvRs [4];
  logic [1:0]  drvWe;
  logic [4:0]  drvRd [2];
  logic [63:0] drvWd [2];
  logic        drvClr;

  multiport_register_file_if #(.DATA_WIDTH(64), .NUM_REGS(32), .ADDR_WIDTH(5),
                               .NUM_READ(2), .NUM_WRITE(2)) ifA ();
  multiport_register_file_if #(.DATA_WIDTH(32), .NUM_REGS(16), .ADDR_WIDTH(4),
                               .NUM_READ(4), .NUM_WRITE(1)) ifB ();

  multiport_register_file #(.DATA_WIDTH(64), .NUM_REGS(32), .ADDR_WIDTH(5),
                            .NUM_READ(2), .NUM_WRITE(2), .ZERO_REG0(1'b1),
                            .BYPASS(1'b1)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (ifA)
  );

  multiport_register_file #(.DATA_WIDTH(32), .NUM_REGS(16), .ADDR_WIDTH(4),
                            .NUM_READ(4), .NUM_WRITE(1), .ZERO_REG0(1'b1),
                            .BYPASS(1'b0)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (ifB)
  );

  // Route the shared driver variables to whichever instance is under test.
  assign ifA.rs        = {drvRs[1], drvRs[0]};
  assign ifA.RegWrite  = phaseB ? 2'b00 : drvWe;
  assign ifA.rd        = {drvRd[1], drvRd[0]};
  assign ifA.WriteData = {drvWd[1], drvWd[0]};
  assign ifA.clear_req = ~phaseB & drvClr;

  assign ifB.rs        = {drvRs[3][3:0], drvRs[2][3:0], drvRs[1][3:0], drvRs[0][3:0]};
  assign ifB.RegWrite  = phaseB ? drvWe[0] : 1'b0;
  assign ifB.rd        = drvRd[0][3:0];
  assign ifB.WriteData = drvWd[0][31:0];
  assign ifB.clear_req = phaseB & drvClr;

  logic            actRdy;
  logic [3:0][63:0] actData;

  // Normalise the active instance's outputs to four 64-bit ports.
  always_comb begin
    actData = '0;
    if (phaseB) begin
      actRdy     = ifB.ready;
      actData[0] = {32'h0, ifB.ReadData[31:0]};
      actData[1] = {32'h0, ifB.ReadData[63:32]};
      actData[2] = {32'h0, ifB.ReadData[95:64]};
      actData[3] = {32'h0, ifB.ReadData[127:96]};
    end else begin
      actRdy     = ifA.ready;
      actData[0] = ifA.ReadData[63:0];
      actData[1] = ifA.ReadData[127:64];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: register contents plus the number of clock edges
  // left before the file becomes usable again.
  logic [63:0] mdl [32];
  int          clearLeft;
  bit          mdlReady;

  logic             expRdyQ [$];
  logic [3:0][63:0] expDataQ [$];
  string            tagQ [$];

  int testsRun;
  int failCount;

  function automatic logic [63:0] expRead(int idx);
    logic [63:0] v;
    if (!mdlReady) return '0;
    if (idx == 0) return '0;
    v = mdl[idx];
    if (cfgBypass) begin
      for (int w = 0; w < cfgWrite; w++) begin
        if (drvWe[w] && (int'(drvRd[w]) == idx)) v = drvWd[w];
      end
    end
    return v;
  endfunction

  task automatic pushExpect(string tag);
    logic [3:0][63:0] e;
    e = '0;
    for (int i = 0; i < cfgRead; i++) e[i] = expRead(int'(drvRs[i]));
    expRdyQ.push_back(mdlReady);
    expDataQ.push_back(e);
    tagQ.push_back(tag);
  endtask

  task automatic modelEdge();
    if (!mdlReady) begin
      clearLeft--;
      if (clearLeft == 0) begin
        for (int r = 0; r < 32; r++) mdl[r] = '0;
        mdlReady = 1'b1;
      end
    end else if (drvClr) begin
      clearLeft = cfgRegs;
      mdlReady  = 1'b0;
    end else begin
      for (int w = 0; w < cfgWrite; w++) begin
        if (drvWe[w] && (drvRd[w] != 5'd0)) mdl[drvRd[w]] = drvWd[w];
      end
    end
  endtask

  // Called just after a rising edge with the driver variables already set:
  // queue the prediction, let the edge commit, update the model.
  task automatic applyStimulus(string tag);
    pushExpect(tag);
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  // Assert reset between clock edges so the response is checked before
  // any edge can hide a synchronous implementation.
  task automatic pulseReset(string tag);
    #1 reset = 1'b1;
    mdlReady  = 1'b0;
    clearLeft = cfgRegs;
    pushExpect(tag);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic driveIdle();
    drvWe  = '0;
    drvClr = 1'b0;
    for (int w = 0; w < 2; w++) begin
      drvRd[w] = '0;
      drvWd[w] = '0;
    end
    for (int i = 0; i < 4; i++) drvRs[i] = 5'($urandom_range(cfgRegs - 1));
  endtask

  task automatic driveRandom(int clrPermille);
    drvClr = ($urandom_range(999) < clrPermille);
    for (int w = 0; w < 2; w++) begin
      drvWe[w] = (w < cfgWrite) && ($urandom_range(1) == 1);
      drvRd[w] = 5'($urandom_range(cfgRegs - 1));
      drvWd[w] = {$urandom, $urandom} & cfgMask;
    end
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(2) == 0) drvRs[i] = drvRd[$urandom_range(cfgWrite - 1)];
      else drvRs[i] = 5'($urandom_range(cfgRegs - 1));
    end
  endtask

  task automatic checkOutput();
    logic             er;
    logic [3:0][63:0] ed;
    string            t;
    er = expRdyQ.pop_front();
    ed = expDataQ.pop_front();
    t  = tagQ.pop_front();
    testsRun++;
    if (actRdy !== er) begin
      failCount++;
      $display("[TB] FAIL %s ready: got %0b expected %0b", t, actRdy, er);
    end
    for (int i = 0; i < cfgRead; i++) begin
      testsRun++;
      if (actData[i] !== ed[i]) begin
        failCount++;
        $display("[TB] FAIL %s ReadData[%0d]: got %h expected %h", t, i, actData[i], ed[i]);
      end
    end
  endtask

  // Monitor: compare the DUT against each queued prediction mid-cycle.
  always @(negedge clk) begin
    if (expRdyQ.size() > 0) checkOutput();
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    testsRun  = 0;
    failCount = 0;
    phaseB    = 1'b0;
    cfgRegs   = 32;
    cfgRead   = 2;
    cfgWrite  = 2;
    cfgBypass = 1'b1;
    cfgMask   = '1;
    mdlReady  = 1'b0;
    clearLeft = cfgRegs;
    for (int r = 0; r < 32; r++) mdl[r] = '0;
    reset = 1'b1;
    driveIdle();
    repeat (2) @(posedge clk);
    #1;

    // ---- dutA: reset sweep then every index reads zero
    pulseReset("initReset");
    for (int c = 0; c < 32; c++) begin driveIdle(); applyStimulus("sweepBusy"); end
    for (int r = 0; r < 32; r++) begin
      driveIdle(); drvRs[0] = 5'(r); drvRs[1] = 5'(31 - r);
      applyStimulus("zeroAfterSweep");
    end

    // ---- bypass and storage of a single write
    driveIdle(); drvWe = 2'b01; drvRd[0] = 5'd5; drvWd[0] = 64'h1234;
    drvRs[0] = 5'd5; drvRs[1] = 5'd5;
    applyStimulus("bypassSameCycle");
    driveIdle(); drvRs[0] = 5'd5; applyStimulus("readBack5");

    // ---- both ports to one index: port 1 wins
    driveIdle(); drvWe = 2'b11; drvRd[0] = 5'd7; drvRd[1] = 5'd7;
    drvWd[0] = 64'hAAAA; drvWd[1] = 64'hBBBB; drvRs[0] = 5'd7;
    applyStimulus("dualWriteBypass");
    driveIdle(); drvRs[0] = 5'd7; drvRs[1] = 5'd7; applyStimulus("dualWriteStored");

    // ---- register 0 is hardwired
    driveIdle(); drvWe = 2'b01; drvRd[0] = 5'd0; drvWd[0] = 64'hFFFF; drvRs[0] = 5'd0;
    applyStimulus("zeroRegSame");
    driveIdle(); drvRs[0] = 5'd0; applyStimulus("zeroRegNext");

    // ---- random traffic with occasional clear requests
    for (int c = 0; c < 300; c++) begin driveRandom(15); applyStimulus("randomA"); end
    for (int c = 0; c < 34; c++) begin driveIdle(); applyStimulus("settleA"); end

    // ---- fill, then clear_req colliding with a write to 9
    for (int r = 1; r < 32; r++) begin
      driveIdle(); drvWe = 2'b01; drvRd[0] = 5'(r); drvWd[0] = 64'(r * 3); drvRs[0] = 5'(r);
      applyStimulus("fill");
    end
    driveIdle(); drvClr = 1'b1; drvWe = 2'b01; drvRd[0] = 5'd9; drvWd[0] = 64'h55;
    drvRs[0] = 5'd3; drvRs[1] = 5'd4;
    applyStimulus("clearReqCycle");
    for (int c = 0; c < 32; c++) begin driveIdle(); applyStimulus("clearSweep"); end
    for (int r = 0; r < 32; r++) begin
      driveIdle(); drvRs[0] = 5'(r); drvRs[1] = 5'd9;
      applyStimulus("zeroAfterClear");
    end

    // ---- async reset while idle, then mid-sweep at counter 10
    driveIdle(); drvWe = 2'b10; drvRd[1] = 5'd12; drvWd[1] = 64'hC0FFEE;
    applyStimulus("preResetWrite");
    driveIdle(); drvRs[0] = 5'd12; pulseReset("resetInIdle");
    for (int c = 0; c < 32; c++) begin driveIdle(); applyStimulus("resetSweep"); end
    driveIdle(); drvClr = 1'b1; applyStimulus("clearForReset");
    for (int c = 0; c < 10; c++) begin driveIdle(); applyStimulus("sweepBeforeReset"); end
    driveIdle(); pulseReset("resetMidSweep");
    for (int c = 0; c < 32; c++) begin driveIdle(); applyStimulus("restartSweep"); end
    for (int r = 0; r < 32; r++) begin
      driveIdle(); drvRs[0] = 5'(r); applyStimulus("zeroAfterRestart");
    end

    // ---- dutB: 4 read ports, 1 write port, no bypass, 16 regs
    driveIdle();
    phaseB    = 1'b1;
    cfgRegs   = 16;
    cfgRead   = 4;
    cfgWrite  = 1;
    cfgBypass = 1'b0;
    cfgMask   = 64'h0000_0000_FFFF_FFFF;
    driveIdle();
    pulseReset("initResetB");
    for (int c = 0; c < 16; c++) begin driveIdle(); applyStimulus("sweepBusyB"); end
    for (int r = 0; r < 16; r++) begin
      driveIdle(); for (int i = 0; i < 4; i++) drvRs[i] = 5'((r + i) % 16);
      applyStimulus("zeroAfterSweepB");
    end
    driveIdle(); drvWe = 2'b01; drvRd[0] = 5'd15; drvWd[0] = 64'hDEADBEEF;
    for (int i = 0; i < 4; i++) drvRs[i] = 5'd15;
    applyStimulus("noBypassSameCycle");
    driveIdle(); for (int i = 0; i < 4; i++) drvRs[i] = 5'd15;
    applyStimulus("allPorts15");
    for (int c = 0; c < 200; c++) begin driveRandom(10); applyStimulus("randomB"); end

    driveIdle();
    repeat (3) @(posedge clk);
    testsRun++;
    if (expRdyQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL drainQueue: got %0d pending expected 0", expRdyQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
